gray_sync_decoder: RTL
======================

Name: gray_sync_decoder

Overview:
Receives the Gray-coded count produced by gray_counter in a foreign clock domain and brings it into the local domain through a multi-flop synchronizer. It converts the synchronized value to binary and emits a one-cycle update strobe when the value changes. It flags illegal multi-bit Gray transitions, which indicate a skipped count or a broken CDC path. It is the consumer stage of the Gray pointer path, used for FIFO pointers and cross-domain event counters.

Parameters:
DATA_WIDTH, 32, width of the Gray input and of all count outputs (min 2)
SYNC_STAGES, 2, synchronizer flop depth (min 2, max 4)

Ports:
clk  input  1  local-domain clock
rst  input  1  reset; asynchronous, active-low
gray_in  input  DATA_WIDTH  Gray count from the foreign domain; asynchronous to clk
err_clr  input  1  clears skip_err
gray_out  output  DATA_WIDTH  synchronized Gray value (last synchronizer stage)
bin_out  output  DATA_WIDTH  binary equivalent of gray_out, registered
upd  output  1  one-cycle pulse; bin_out took a new, different value this cycle
skip_err  output  1  sticky; a synchronized transition changed more than one bit
primed  output  1  high once the synchronizer holds post-reset data

Behaviour:
- Reset (rst=0, async): all sync flops, gray_out, bin_out, prev-Gray register and prime counter go to 0; upd=0, skip_err=0, primed=0.
- Synchronizer: gray_in passes through SYNC_STAGES flops with no logic between them. gray_out is the last stage.
- Conversion: on each clk, bin_out <= gray2bin(gray_out), where bin[W-1]=g[W-1] and bin[i]=bin[i+1]^g[i]. Latency from a stable gray_in to bin_out is SYNC_STAGES+1 edges.
- Prime FSM, two states:
  - PRIME: counter runs 0..SYNC_STAGES after reset release; go to RUN when it reaches SYNC_STAGES.
  - RUN: terminal until reset. primed=1 in RUN only.
- Change detect: prev_g holds the gray_out value sampled on the previous edge. In RUN, if gray_out != prev_g, then upd=1 on the same edge that bin_out updates. Otherwise upd=0. In PRIME, upd is forced to 0.
- Skip check: in RUN, if popcount(gray_out ^ prev_g) > 1, set skip_err. On err_clr=1, clear it. If set and clear occur in the same cycle, set wins.
- Wrap-around: Gray of 2^W-1 to 0 is a single-bit change and is legal. bin_out wraps to 0 with upd=1 and no error.
- Back-to-back changes on consecutive cycles each produce an upd pulse; there is no coalescing.
- A reset asserted mid-operation clears everything immediately. After release, priming restarts and no upd is issued for SYNC_STAGES+1 cycles.

Optional Feature:
Macro GRAY_SYNC_DELTA_EN.
- Defined: adds output delta_out [DATA_WIDTH]. It is registered alongside bin_out and equals new_bin - old_bin mod 2^DATA_WIDTH when upd=1, and holds its previous value otherwise. Reset value is 0. It equals 1 for normal single-step counting.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package gray_pkg holds:
  - function gray2bin (parameterized by width)
  - function multi_bit_change (popcount > 1)
  - constants PRIME_CNT_W=3 and SYNC_STAGES_MAX=4
  - typedef of the prime-FSM state enum {PRIME, RUN}
- Sub-module sync_chain (DATA_WIDTH, SYNC_STAGES, async active-low reset). It is reused by other CDC blocks and carries the synthesis keep/ASYNC_REG attributes.

Test Plan (DATA_WIDTH=4, SYNC_STAGES=2):
- Reset: drive rst=0 with gray_in=0110 → gray_out=0, bin_out=0, upd=0, skip_err=0, primed=0. Release: primed=1 after 3 edges, and no upd while gray_in stays 0110 from reset.
- Single step: gray_in 0000→0001 after priming, held → bin_out=0001 and upd pulses for exactly 1 cycle, 3 edges after the change.
- Full sweep: drive the Gray sequence 0..15 with each value held 4 cycles, including 1000→0000 → bin_out goes 0..15 then 0, 16 upd pulses, skip_err stays 0. With the macro on, delta_out=1 throughout.
- Illegal jump: 0001→0010 (2 bits) → skip_err=1, bin_out=0011, upd=1. err_clr=1 on a later idle cycle gives skip_err=0. A new illegal jump on the same cycle as err_clr leaves skip_err=1.
- Reset mid-op: bin_out=0111, assert rst asynchronously between edges → all outputs are 0 before the next edge. After release, no upd for 3 edges even though gray_in=0100.
- Fast change: gray_in 0011→0010→0110 on consecutive cycles → two upd pulses on consecutive cycles, bin_out 2→3→4. With the macro on, delta_out=1, 1.

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, constants and Gray helpers for the Gray pointer path
package gray_pkg;

    localparam int PRIME_CNT_W     = 3;
    localparam int SYNC_STAGES_MAX = 4;

    // Helpers operate at this width; callers zero-extend narrower values,
    // which leaves the low bits of the result unchanged.
    localparam int GRAY_MAX_W      = 64;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } prime_state_e;

    // bin[MSB] = g[MSB], bin[i] = bin[i+1] ^ g[i]
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit differs between two Gray samples
    function automatic logic multi_bit_change(input logic [GRAY_MAX_W-1:0] diff);
        return ($countones(diff) > 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop CDC synchronizer, no logic between stages
module sync_chain #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    (* ASYNC_REG = "TRUE", keep = "true" *)
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

    // Shift the foreign-domain value through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// rtl/gray_sync_decoder.sv - Gray count synchronizer/decoder; optional GRAY_SYNC_DELTA_EN adds delta_out
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gray_in,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  upd,
    output logic                  skip_err,
`ifdef GRAY_SYNC_DELTA_EN
    output logic [DATA_WIDTH-1:0] delta_out,
`endif
    output logic                  primed
);

    logic [DATA_WIDTH-1:0]  gray_sync;

    prime_state_e           state_q, state_d;
    logic [PRIME_CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]  prev_g_q, prev_g_d;
    logic [DATA_WIDTH-1:0]  bin_q, bin_d;
    logic                   upd_q, upd_d;
    logic                   skip_q, skip_d;

    logic [DATA_WIDTH-1:0]  gray_diff;
    logic                   run;

    sync_chain #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk    (clk),
        .rst_n  (rst),
        .data_i (gray_in),
        .data_o (gray_sync)
    );

    // Prime FSM register: counts out the synchronizer fill after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PRIME;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Prime FSM next state: hold off change detection until the chain holds post-reset data
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PRIME: begin
                if (cnt_q == PRIME_CNT_W'(SYNC_STAGES)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + PRIME_CNT_W'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = PRIME;
        endcase
    end

    assign run       = (state_q == RUN);
    assign gray_diff = gray_sync ^ prev_g_q;

    // Datapath next state: decode, change strobe and sticky skip flag (set beats clear)
    always_comb begin
        prev_g_d = gray_sync;
        bin_d    = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(gray_sync)));
        upd_d    = run && (gray_diff != '0);
        skip_d   = skip_q;
        if (run && multi_bit_change(GRAY_MAX_W'(gray_diff))) begin
            skip_d = 1'b1;
        end else if (err_clr) begin
            skip_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_g_q <= '0;
            bin_q    <= '0;
            upd_q    <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            prev_g_q <= prev_g_d;
            bin_q    <= bin_d;
            upd_q    <= upd_d;
            skip_q   <= skip_d;
        end
    end

`ifdef GRAY_SYNC_DELTA_EN
    logic [DATA_WIDTH-1:0] delta_q, delta_d;

    // Step size between consecutive decoded values, modulo 2^DATA_WIDTH
    always_comb begin
        delta_d = delta_q;
        if (upd_d) begin
            delta_d = bin_d - bin_q;
        end
    end

    // Delta register, updated only alongside an upd pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delta_q <= '0;
        end else begin
            delta_q <= delta_d;
        end
    end

    assign delta_out = delta_q;
`endif

    assign gray_out = gray_sync;
    assign bin_out  = bin_q;
    assign upd      = upd_q;
    assign skip_err = skip_q;
    assign primed   = run;

endmodule
